// File: rtl/mv_avg_multi_ch_if.sv
// ============================================================================
// Module   : mv_avg_multi_ch_if
// Brief    : Sample-in / average-out bundle for the multi-channel averager.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

interface mv_avg_multi_ch_if #(
  parameter int NUM_CH     = 2,
  parameter int DATA_WIDTH = 16
);
  logic [NUM_CH*DATA_WIDTH-1:0] data_in;
  logic                         data_in_valid;
  logic [NUM_CH*DATA_WIDTH-1:0] data_out;
  logic                         data_out_valid;
  logic                         window_full;

  modport master (
    output data_in,
    output data_in_valid,
    input  data_out,
    input  data_out_valid,
    input  window_full
  );

  modport slave (
    input  data_in,
    input  data_in_valid,
    output data_out,
    output data_out_valid,
    output window_full
  );
endinterface

`default_nettype wire

// File: rtl/mv_avg_multi_ch.sv
// ============================================================================
// Module   : mv_avg_multi_ch
// Brief    : N-channel power-of-two moving average, run-time window length,
//            shared circular history buffer. Macro MV_AVG_ROUND_EN selects
//            round-half-up instead of floor on the final shift.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module mv_avg_multi_ch #(
  parameter int NUM_CH       = 2,
  parameter int DATA_WIDTH   = 16,
  parameter int LOG2_MAX_LEN = 6
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 clear,
  input  logic [3:0]           log2_len,
  mv_avg_multi_ch_if.slave     bus
);

  localparam int c_DEPTH  = 1 << LOG2_MAX_LEN;
  localparam int c_PTR_W  = LOG2_MAX_LEN;
  localparam int c_FILL_W = LOG2_MAX_LEN + 1;
  localparam int c_TOT_W  = DATA_WIDTH + LOG2_MAX_LEN;
  localparam int c_BUS_W  = NUM_CH * DATA_WIDTH;
  localparam logic [3:0]          c_MAX_LEN   = 4'(LOG2_MAX_LEN);
  localparam logic [c_FILL_W-1:0] c_DEPTH_CNT = c_FILL_W'(c_DEPTH);

  logic [c_BUS_W-1:0]  r_buf [c_DEPTH];
  logic [c_PTR_W-1:0]  r_wr_ptr;
  logic [c_FILL_W-1:0] r_fill_cnt;
  logic [3:0]          r_len;
  logic                r_out_valid;
  logic                r_window_full;

  logic                w_accept;
  logic [3:0]          w_len_clamped;
  logic [c_FILL_W-1:0] w_win;
  logic [c_FILL_W-1:0] w_fill_next;
  logic [c_PTR_W-1:0]  w_rd_ptr;
  logic                w_sub_en;
  logic [c_BUS_W-1:0]  w_old_word;
  logic [c_BUS_W-1:0]  w_data_out;
  logic signed [c_TOT_W-1:0] w_rnd;

  assign w_accept      = bus.data_in_valid & ~clear;
  assign w_len_clamped = (log2_len > c_MAX_LEN) ? c_MAX_LEN : log2_len;
  assign w_win         = c_FILL_W'(1) << r_len;
  assign w_fill_next   = (r_fill_cnt == c_DEPTH_CNT) ? r_fill_cnt : r_fill_cnt + 1'b1;
  // At full depth the window size wraps to zero in pointer width, so the
  // oldest entry is the slot about to be overwritten.
  assign w_rd_ptr      = r_wr_ptr - w_win[c_PTR_W-1:0];
  assign w_sub_en      = (r_fill_cnt >= w_win);
  assign w_old_word    = r_buf[w_rd_ptr];

`ifdef MV_AVG_ROUND_EN
  assign w_rnd = (r_len == 4'd0) ? '0 : (c_TOT_W'(1) << (r_len - 4'd1));
`else
  assign w_rnd = '0;
`endif

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_buf[r_wr_ptr] <= bus.data_in;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wr_ptr      <= '0;
      r_fill_cnt    <= '0;
      r_len         <= '0;
      r_out_valid   <= 1'b0;
      r_window_full <= 1'b0;
    end else begin
      r_out_valid <= w_accept;
      if (clear) begin
        r_fill_cnt    <= '0;
        r_len         <= w_len_clamped;
        r_window_full <= 1'b0;
      end else begin
        // Length tracks the request only while the window is empty.
        if (r_fill_cnt == '0) begin
          r_len <= w_len_clamped;
        end
        if (w_accept) begin
          r_wr_ptr      <= r_wr_ptr + 1'b1;
          r_fill_cnt    <= w_fill_next;
          r_window_full <= (w_fill_next >= w_win);
        end
      end
    end
  end

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
    logic [DATA_WIDTH-1:0]     w_new;
    logic [DATA_WIDTH-1:0]     w_old;
    logic signed [c_TOT_W-1:0] w_new_x;
    logic signed [c_TOT_W-1:0] w_old_x;
    logic signed [c_TOT_W-1:0] w_total_next;
    logic [DATA_WIDTH-1:0]     w_avg;
    logic signed [c_TOT_W-1:0] r_total;
    logic [DATA_WIDTH-1:0]     r_out;

    assign w_new        = bus.data_in[ch*DATA_WIDTH +: DATA_WIDTH];
    assign w_old        = w_sub_en ? w_old_word[ch*DATA_WIDTH +: DATA_WIDTH] : '0;
    assign w_new_x      = {{LOG2_MAX_LEN{w_new[DATA_WIDTH-1]}}, w_new};
    assign w_old_x      = {{LOG2_MAX_LEN{w_old[DATA_WIDTH-1]}}, w_old};
    assign w_total_next = r_total + w_new_x - w_old_x;
    assign w_avg        = DATA_WIDTH'((w_total_next + w_rnd) >>> r_len);

    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        r_total <= '0;
        r_out   <= '0;
      end else if (clear) begin
        r_total <= '0;
        r_out   <= '0;
      end else if (w_accept) begin
        r_total <= w_total_next;
        r_out   <= w_avg;
      end
    end

    assign w_data_out[ch*DATA_WIDTH +: DATA_WIDTH] = r_out;
  end

  assign bus.data_out       = w_data_out;
  assign bus.data_out_valid = r_out_valid;
  assign bus.window_full    = r_window_full;

endmodule

`default_nettype wire

// File: tb/tb_mv_avg_multi_ch.sv
// ============================================================================
// Module   : tb_mv_avg_multi_ch
// Brief    : Scoreboard bench for mv_avg_multi_ch (windowed-sum reference).
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_mv_avg_multi_ch;

  localparam int NUM_CH = 2;
  localparam int DW     = 16;
  localparam int LMAX   = 6;
  localparam int DEPTH  = 1 << LMAX;
  localparam int BW     = NUM_CH * DW;

  typedef struct {
    logic [BW-1:0] dout;
    logic          wf;
  } sb_t;

  logic       clk = 1'b0;
  logic       rstn;
  logic       clear;
  logic [3:0] log2_len;

  mv_avg_multi_ch_if #(.NUM_CH(NUM_CH), .DATA_WIDTH(DW)) bus ();

  mv_avg_multi_ch #(
    .NUM_CH       (NUM_CH),
    .DATA_WIDTH   (DW),
    .LOG2_MAX_LEN (LMAX)
  ) dut (
    .clk      (clk),
    .rstn     (rstn),
    .clear    (clear),
    .log2_len (log2_len),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  int            n_chk  = 0;
  int            n_pass = 0;
  sb_t           sb [$];
  logic [BW-1:0] hist [$];
  int            m_len = 0;

  task automatic chk(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  function automatic int clamp(input logic [3:0] l);
    return (int'(l) > LMAX) ? LMAX : int'(l);
  endfunction

  function automatic logic [BW-1:0] pack(input int a, input int b);
    logic [31:0] ua, ub;
    ua = a;
    ub = b;
    return {ub[DW-1:0], ua[DW-1:0]};
  endfunction

  function automatic longint dout_ch(input int ch);
    logic signed [DW-1:0] s;
    s = bus.data_out[ch*DW +: DW];
    return longint'(s);
  endfunction

  // Reference: sum of the newest min(count, 2^len) samples, scaled by 2^len.
  function automatic logic [BW-1:0] model_avg();
    logic [BW-1:0]        res;
    logic signed [DW-1:0] s;
    longint               sum;
    int                   n;
    n = (hist.size() < (1 << m_len)) ? hist.size() : (1 << m_len);
    for (int ch = 0; ch < NUM_CH; ch++) begin
      sum = 0;
      for (int i = 0; i < n; i++) begin
        s = hist[i][ch*DW +: DW];
        sum += longint'(s);
      end
`ifdef MV_AVG_ROUND_EN
      if (m_len > 0) sum += longint'(1) << (m_len - 1);
`endif
      sum = sum >>> m_len;
      res[ch*DW +: DW] = sum[DW-1:0];
    end
    return res;
  endfunction

  task automatic tick(input logic v, input logic c, input logic [BW-1:0] d);
    sb_t e;
    bit  acc;
    int  n_before;
    bus.data_in       = d;
    bus.data_in_valid = v;
    clear             = c;
    acc      = v && !c;
    n_before = hist.size();
    if (c) begin
      hist.delete();
      m_len = clamp(log2_len);
    end else begin
      if (acc) begin
        hist.push_front(d);
        if (hist.size() > DEPTH) void'(hist.pop_back());
        e.dout = model_avg();
        e.wf   = (hist.size() >= (1 << m_len));
        sb.push_back(e);
      end
      if (n_before == 0) m_len = clamp(log2_len);
    end
    @(posedge clk);
    #1;
    chk("valid", longint'(bus.data_out_valid), longint'(acc));
    if (bus.data_out_valid) begin
      if (sb.size() == 0) chk("sb_underflow", 1, 0);
      else begin
        e = sb.pop_front();
        chk("sb_dout", longint'(bus.data_out), longint'(e.dout));
        chk("sb_wfull", longint'(bus.window_full), longint'(e.wf));
      end
    end
  endtask

  task automatic model_reset();
    hist.delete();
    sb.delete();
    m_len = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t1_exp [5] = '{1, 3, 6, 10, 14};
`ifdef MV_AVG_ROUND_EN
    int t2_exp [10] = '{-12, -25, -37, -50, -62, -75, -87, -100, -100, -100};
`else
    int t2_exp [10] = '{-13, -25, -38, -50, -63, -75, -88, -100, -100, -100};
`endif
    logic [BW-1:0] d;

    rstn              = 1'b0;
    clear             = 1'b0;
    log2_len          = 4'd0;
    bus.data_in       = '0;
    bus.data_in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_dout", longint'(bus.data_out), 0);
    chk("rst_valid", longint'(bus.data_out_valid), 0);
    chk("rst_wfull", longint'(bus.window_full), 0);
    rstn     = 1'b1;
    log2_len = 4'd2;
    tick(0, 0, '0);

    // Contiguous ramp, window 4.
    for (int i = 0; i < 5; i++) begin
      tick(1, 0, pack(4 * (i + 1), int'($urandom_range(0, 1000))));
      chk("t1_ch0", dout_ch(0), t1_exp[i]);
      chk("t1_wfull", longint'(bus.window_full), (i >= 3) ? 1 : 0);
    end

    // Constant negative input on ch1, window 8.
    log2_len = 4'd3;
    tick(0, 1, '0);
    chk("clr_dout", longint'(bus.data_out), 0);
    chk("clr_wfull", longint'(bus.window_full), 0);
    for (int i = 0; i < 10; i++) begin
      tick(1, 0, pack(int'($urandom_range(0, 65535)), -100));
      chk("t2_ch1", dout_ch(1), t2_exp[i]);
    end

    // Same ramp with valid on every third cycle.
    log2_len = 4'd2;
    tick(0, 1, '0);
    for (int i = 0; i < 5; i++) begin
      tick(1, 0, pack(4 * (i + 1), int'($urandom_range(0, 65535))));
      chk("t3_ch0", dout_ch(0), t1_exp[i]);
      tick(0, 0, pack(999, 999));
      tick(0, 0, pack(777, 777));
    end

    // Length request change without clear is ignored; clear applies it.
    for (int i = 0; i < 3; i++) tick(1, 0, pack(int'($urandom), int'($urandom)));
    log2_len = 4'd0;
    for (int i = 0; i < 6; i++) tick(1, 0, pack(int'($urandom), int'($urandom)));
    tick(0, 1, '0);
    for (int i = 0; i < 5; i++) begin
      d = pack(int'($urandom), int'($urandom));
      tick(1, 0, d);
      chk("t4_pass", longint'(bus.data_out), longint'(d));
    end

    // Clear collides with a valid sample.
    log2_len = 4'd2;
    tick(0, 1, '0);
    tick(1, 0, pack(8, 8));
    tick(1, 0, pack(12, 12));
    tick(1, 1, pack(50, 50));
    chk("cv_dout", longint'(bus.data_out), 0);
    chk("cv_wfull", longint'(bus.window_full), 0);

    // Asynchronous reset mid-window.
    for (int i = 0; i < 3; i++) tick(1, 0, pack(int'($urandom), int'($urandom)));
    bus.data_in_valid = 1'b0;
    #2;
    rstn = 1'b0;
    model_reset();
    #1;
    chk("mid_rst_dout", longint'(bus.data_out), 0);
    chk("mid_rst_valid", longint'(bus.data_out_valid), 0);
    chk("mid_rst_wfull", longint'(bus.window_full), 0);
    @(negedge clk);
    rstn = 1'b1;
    tick(0, 0, '0);
    tick(1, 0, pack(40, -40));
    chk("post_rst_ch0", dout_ch(0), 10);
    chk("post_rst_ch1", dout_ch(1), -10);

    // Rounding behaviour at window 2.
    log2_len = 4'd1;
    tick(0, 1, '0);
    tick(1, 0, pack(1, -1));
`ifdef MV_AVG_ROUND_EN
    chk("rnd1_ch0", dout_ch(0), 1);
    chk("rnd1_ch1", dout_ch(1), 0);
`else
    chk("rnd1_ch0", dout_ch(0), 0);
    chk("rnd1_ch1", dout_ch(1), -1);
`endif
    tick(1, 0, pack(2, -2));
`ifdef MV_AVG_ROUND_EN
    chk("rnd2_ch0", dout_ch(0), 2);
    chk("rnd2_ch1", dout_ch(1), -1);
`else
    chk("rnd2_ch0", dout_ch(0), 1);
    chk("rnd2_ch1", dout_ch(1), -2);
`endif

    // Over-range request clamps to full depth; long run wraps the buffer.
    log2_len = 4'd15;
    tick(0, 1, '0);
    for (int i = 0; i < 150; i++) begin
      log2_len = 4'($urandom_range(0, 15));
      tick($urandom_range(0, 3) != 0, 0, pack(int'($urandom), int'($urandom)));
    end

    // Random traffic with sporadic clears at window 32.
    log2_len = 4'd5;
    tick(0, 1, '0);
    for (int i = 0; i < 120; i++) begin
      tick($urandom_range(0, 2) != 0, $urandom_range(0, 39) == 0,
           pack(int'($urandom), int'($urandom)));
    end

    tick(0, 0, '0);
    chk("sb_empty", longint'(sb.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
